// File: rtl/cpx_pkg.sv
// Shared opcode map, instruction field layout and defaults for the complex issue stage.
package cpx_pkg;

  localparam int unsigned OP_SIZE    = 4;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned REG_AW     = 3;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RA_MSB  = 8;
  localparam int unsigned RA_LSB  = 6;
  localparam int unsigned RB_MSB  = 5;
  localparam int unsigned RB_LSB  = 3;
  localparam int unsigned RSV_MSB = 2;

  localparam logic [OP_SIZE-1:0] ADD_OP     = 4'b0000;
  localparam logic [OP_SIZE-1:0] SUB_OP     = 4'b0001;
  localparam logic [OP_SIZE-1:0] MUL_OP     = 4'b0010;
  localparam logic [OP_SIZE-1:0] DIV_OP     = 4'b0011;
  localparam logic [OP_SIZE-1:0] REAL_OP    = 4'b0100;
  localparam logic [OP_SIZE-1:0] IMAGINE_OP = 4'b0101;
  localparam logic [OP_SIZE-1:0] CONJ_OP    = 4'b0110;
  localparam logic [OP_SIZE-1:0] MEM_ACCESS = 4'b0111;
  localparam logic [OP_SIZE-1:0] MEM_RD_OP  = 4'b1000;
  localparam logic [OP_SIZE-1:0] LESS_OP    = 4'b1001;
  localparam logic [OP_SIZE-1:0] EQUAL_OP   = 4'b1010;
  localparam logic [OP_SIZE-1:0] LORE_OP    = 4'b1011;
  localparam logic [OP_SIZE-1:0] GREAT_OP   = 4'b1100;
  localparam logic [OP_SIZE-1:0] NEQUAL_OP  = 4'b1101;
  localparam logic [OP_SIZE-1:0] GORE_OP    = 4'b1110;
  localparam logic [OP_SIZE-1:0] MEM_WR_OP  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic logic op_is_math(input logic [OP_SIZE-1:0] op);
    return (op == ADD_OP) || (op == SUB_OP) || (op == MUL_OP);
  endfunction

  function automatic logic op_is_cmp(input logic [OP_SIZE-1:0] op);
    case (op)
      LESS_OP, EQUAL_OP, LORE_OP, GREAT_OP, NEQUAL_OP, GORE_OP: return 1'b1;
      default:                                                  return 1'b0;
    endcase
  endfunction

  // Math and compare ops read a second register; single-operand ops drive B as zero
  function automatic logic op_uses_rb(input logic [OP_SIZE-1:0] op);
    return op_is_math(op) || op_is_cmp(op);
  endfunction

  // Divide and memory ops belong to other units and are rejected here
  function automatic logic op_is_supported(input logic [OP_SIZE-1:0] op);
    case (op)
      DIV_OP, MEM_ACCESS, MEM_RD_OP, MEM_WR_OP: return 1'b0;
      default:                                  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/cpx_regfile.sv
// Complex register file: one write port, two operand read ports and a debug read port.
module cpx_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 8,
  parameter int unsigned AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wre,
  input  logic [DATA_W-1:0] i_wim,
  input  logic [AW-1:0]     i_ra_addr,
  input  logic [AW-1:0]     i_rb_addr,
  input  logic [AW-1:0]     i_dbg_addr,
  output logic [DATA_W-1:0] o_ra_re,
  output logic [DATA_W-1:0] o_ra_im,
  output logic [DATA_W-1:0] o_rb_re,
  output logic [DATA_W-1:0] o_rb_im,
  output logic [DATA_W-1:0] o_dbg_re,
  output logic [DATA_W-1:0] o_dbg_im
);

  logic [DATA_W-1:0] r_re [NREG];
  logic [DATA_W-1:0] r_im [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else if (i_we) begin
      r_re[i_waddr] <= i_wre;
      r_im[i_waddr] <= i_wim;
    end
  end

  // Reads see the stored value, so a same-cycle write is not visible until the next cycle
  assign o_ra_re  = r_re[i_ra_addr];
  assign o_ra_im  = r_im[i_ra_addr];
  assign o_rb_re  = r_re[i_rb_addr];
  assign o_rb_im  = r_im[i_rb_addr];
  assign o_dbg_re = r_re[i_dbg_addr];
  assign o_dbg_im = r_im[i_dbg_addr];

endmodule

// File: rtl/cpx_issue.sv
// Issue/writeback stage in front of the complex ALU: decodes one instruction at a time,
// drives the ALU operands and retires the ALU result or compare flag.
module cpx_issue #(
  parameter int unsigned DATA_W  = cpx_pkg::DEF_DATA_W,
  parameter int unsigned NREG    = 8,
  parameter int unsigned OP_SIZE = cpx_pkg::OP_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [cpx_pkg::INSTR_W-1:0] instr,
  input  logic                        ld_valid,
  input  logic [$clog2(NREG)-1:0]     ld_addr,
  input  logic [DATA_W-1:0]           ld_re,
  input  logic [DATA_W-1:0]           ld_im,
  input  logic [$clog2(NREG)-1:0]     dbg_addr,
  output logic [DATA_W-1:0]           dbg_re,
  output logic [DATA_W-1:0]           dbg_im,
  output logic [DATA_W-1:0]           A1,
  output logic [DATA_W-1:0]           A2,
  output logic [DATA_W-1:0]           B1,
  output logic [DATA_W-1:0]           B2,
  output logic [7:0]                  Op,
  input  logic [DATA_W-1:0]           Out1,
  input  logic [DATA_W-1:0]           Out2,
  input  logic                        CompReg,
  output logic                        cmp_flag,
  output logic                        done,
  output logic                        err
);

  import cpx_pkg::*;

  localparam int unsigned AW = $clog2(NREG);

  state_t              r_state;
  state_t              w_next;
  logic [AW-1:0]       r_rd;
  logic [OP_SIZE-1:0]  r_op;
  logic [DATA_W-1:0]   r_a1, r_a2, r_b1, r_b2;
  logic                r_cmp_flag, r_done, r_err;

  logic [OP_SIZE-1:0]  w_op;
  logic [AW-1:0]       w_rd, w_ra, w_rb;
  logic [DATA_W-1:0]   w_ra_re, w_ra_im, w_rb_re, w_rb_im;
  logic                w_rf_we;
  logic [AW-1:0]       w_rf_waddr;
  logic [DATA_W-1:0]   w_rf_wre, w_rf_wim;
  logic                w_issue, w_reject, w_retire, w_cmp_load;
  logic                w_unused_rsv;

  assign w_op = OP_SIZE'(instr[OP_MSB:OP_LSB]);
  assign w_rd = AW'(instr[RD_MSB:RD_LSB]);
  assign w_ra = AW'(instr[RA_MSB:RA_LSB]);
  assign w_rb = AW'(instr[RB_MSB:RB_LSB]);
  assign w_unused_rsv = ^instr[RSV_MSB:0];

  cpx_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (AW)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_rf_we),
    .i_waddr    (w_rf_waddr),
    .i_wre      (w_rf_wre),
    .i_wim      (w_rf_wim),
    .i_ra_addr  (w_ra),
    .i_rb_addr  (w_rb),
    .i_dbg_addr (dbg_addr),
    .o_ra_re    (w_ra_re),
    .o_ra_im    (w_ra_im),
    .o_rb_re    (w_rb_re),
    .o_rb_im    (w_rb_im),
    .o_dbg_re   (dbg_re),
    .o_dbg_im   (dbg_im)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state plus register-file write steering; loads win over instruction accept
  always_comb begin
    w_next     = r_state;
    w_rf_we    = 1'b0;
    w_rf_waddr = ld_addr;
    w_rf_wre   = ld_re;
    w_rf_wim   = ld_im;
    w_issue    = 1'b0;
    w_reject   = 1'b0;
    w_retire   = 1'b0;
    w_cmp_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (ld_valid) begin
          w_rf_we = 1'b1;
        end else if (instr_valid) begin
          if (op_is_supported(w_op)) begin
            w_issue = 1'b1;
            w_next  = EXEC;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      EXEC: w_next = WB;
      WB: begin
        w_next   = IDLE;
        w_retire = 1'b1;
        if (op_is_cmp(r_op)) begin
          w_cmp_load = 1'b1;
        end else begin
          w_rf_we    = 1'b1;
          w_rf_waddr = r_rd;
          w_rf_wre   = Out1;
          w_rf_wim   = Out2;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd       <= '0;
      r_op       <= '0;
      r_a1       <= '0;
      r_a2       <= '0;
      r_b1       <= '0;
      r_b2       <= '0;
      r_cmp_flag <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= w_retire;
      r_err  <= w_reject;
      if (w_issue) begin
        r_op <= w_op;
        r_rd <= w_rd;
        r_a1 <= w_ra_re;
        r_a2 <= w_ra_im;
        if (op_uses_rb(w_op)) begin
          r_b1 <= w_rb_re;
          r_b2 <= w_rb_im;
        end else begin
          r_b1 <= '0;
          r_b2 <= '0;
        end
      end
      if (w_cmp_load) r_cmp_flag <= CompReg;
    end
  end

  assign instr_ready = (r_state == IDLE) && !ld_valid && !rst;
  assign A1          = r_a1;
  assign A2          = r_a2;
  assign B1          = r_b1;
  assign B2          = r_b2;
  assign Op          = 8'(r_op);
  assign cmp_flag    = r_cmp_flag;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_cpx_issue.sv
// Directed bench for cpx_issue with a small registered complex-ALU model on the ALU ports.
module tb_cpx_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_re, ld_im;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_re, dbg_im;
  logic [7:0]  A1, A2, B1, B2;
  logic [7:0]  Op;
  logic [7:0]  Out1, Out2;
  logic        CompReg;
  logic        cmp_flag, done, err;

  int checks = 0;
  int errors = 0;
  logic [7:0] er [8];
  logic [7:0] ei [8];

  always #5 clk = ~clk;

  cpx_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_re(ld_re), .ld_im(ld_im),
    .dbg_addr(dbg_addr), .dbg_re(dbg_re), .dbg_im(dbg_im),
    .A1(A1), .A2(A2), .B1(B1), .B2(B2), .Op(Op),
    .Out1(Out1), .Out2(Out2), .CompReg(CompReg),
    .cmp_flag(cmp_flag), .done(done), .err(err)
  );

  // Complex ALU: result registered one edge after the operands appear
  always_ff @(posedge clk) begin
    if (rst) begin
      Out1 <= '0; Out2 <= '0; CompReg <= 1'b0;
    end else begin
      case (Op[3:0])
        4'd0:  begin Out1 <= A1 + B1; Out2 <= A2 + B2; end
        4'd1:  begin Out1 <= A1 - B1; Out2 <= A2 - B2; end
        4'd2:  begin Out1 <= 8'(A1 * B1 - A2 * B2); Out2 <= 8'(A1 * B2 + A2 * B1); end
        4'd4:  begin Out1 <= A1; Out2 <= 8'd0; end
        4'd5:  begin Out1 <= A2; Out2 <= 8'd0; end
        4'd6:  begin Out1 <= A1; Out2 <= 8'd0 - A2; end
        4'd9:  CompReg <= (A1 < B1);
        4'd10: CompReg <= (A1 == B1) && (A2 == B2);
        4'd11: CompReg <= (A1 <= B1);
        4'd12: CompReg <= (A1 > B1);
        4'd13: CompReg <= (A1 != B1) || (A2 != B2);
        4'd14: CompReg <= (A1 >= B1);
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input int idx, input string tag);
    dbg_addr = 3'(idx);
    #1;
    chk($sformatf("%s_r%0d_re", tag, idx), 32'(dbg_re), 32'(er[idx]));
    chk($sformatf("%s_r%0d_im", tag, idx), 32'(dbg_im), 32'(ei[idx]));
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 8; i++) chk_reg(i, tag);
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  task automatic load(input logic [2:0] a, input logic [7:0] re, input logic [7:0] im);
    ld_valid = 1'b1; ld_addr = a; ld_re = re; ld_im = im;
    step();
    ld_valid = 1'b0;
    er[a] = re; ei[a] = im;
  endtask

  // Accept, then check the retire two edges later
  task automatic run(input string tag, input logic [15:0] w, input logic [2:0] rd,
                     input logic [7:0] xre, input logic [7:0] xim);
    instr_valid = 1'b1; instr = w;
    step();
    instr_valid = 1'b0;
    chk({tag, "_ready_exec"}, 32'(instr_ready), 0);
    step();
    chk({tag, "_done_early"}, 32'(done), 0);
    chk_reg(int'(rd), {tag, "_prewrite"});
    step();
    chk({tag, "_done"}, 32'(done), 1);
    er[rd] = xre; ei[rd] = xim;
    chk_reg(int'(rd), tag);
    step();
    chk({tag, "_done_clr"}, 32'(done), 0);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; ld_valid = 1'b0;
    ld_addr = '0; ld_re = '0; ld_im = '0; dbg_addr = '0;
    for (int i = 0; i < 8; i++) begin er[i] = '0; ei[i] = '0; end
    step(); step();
    chk("rst_ready", 32'(instr_ready), 0);
    chk("rst_a1", 32'(A1), 0);
    chk("rst_b2", 32'(B2), 0);
    chk("rst_op", 32'(Op), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_flag", 32'(cmp_flag), 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(instr_ready), 1);
    chk_all("rst");

    load(3'd1, 8'd5, 8'd6);
    load(3'd2, 8'd7, 8'd8);
    chk_reg(1, "load");
    chk_reg(2, "load");

    // ADD r3 = r1 + r2, with operand drive checked in EXEC
    instr_valid = 1'b1; instr = mk(4'b0000, 3'd3, 3'd1, 3'd2);
    step();
    instr_valid = 1'b0;
    chk("add_a1", 32'(A1), 5);
    chk("add_a2", 32'(A2), 6);
    chk("add_b1", 32'(B1), 7);
    chk("add_b2", 32'(B2), 8);
    chk("add_op", 32'(Op), 0);
    chk("add_ready", 32'(instr_ready), 0);
    step();
    chk("add_done_early", 32'(done), 0);
    chk_reg(3, "add_prewrite");
    step();
    chk("add_done", 32'(done), 1);
    er[3] = 8'd12; ei[3] = 8'd14;
    chk_reg(3, "add");
    step();
    chk("add_done_clr", 32'(done), 0);

    run("sub", mk(4'b0001, 3'd4, 3'd1, 3'd2), 3'd4, 8'd254, 8'd254);
    load(3'd5, 8'd1, 8'd1);
    run("mul", mk(4'b0010, 3'd6, 3'd5, 3'd5), 3'd6, 8'd0, 8'd2);

    // CONJ drives B as zero even though rb names a non-zero register
    instr_valid = 1'b1; instr = mk(4'b0110, 3'd7, 3'd1, 3'd2);
    step();
    instr_valid = 1'b0;
    chk("conj_b1", 32'(B1), 0);
    chk("conj_b2", 32'(B2), 0);
    chk("conj_op", 32'(Op), 6);
    step(); step();
    chk("conj_done", 32'(done), 1);
    er[7] = 8'd5; ei[7] = 8'd250;
    chk_reg(7, "conj");
    step();

    run("real", mk(4'b0100, 3'd7, 3'd1, 3'd2), 3'd7, 8'd5, 8'd0);

    // EQUAL r1,r1: flag set, no register written even though rd=r3
    instr_valid = 1'b1; instr = mk(4'b1010, 3'd3, 3'd1, 3'd1);
    step();
    instr_valid = 1'b0;
    step(); step();
    chk("eq_done", 32'(done), 1);
    chk("eq_flag", 32'(cmp_flag), 1);
    chk_all("eq");
    step();

    instr_valid = 1'b1; instr = mk(4'b1001, 3'd4, 3'd2, 3'd1);
    step();
    instr_valid = 1'b0;
    step(); step();
    chk("less_done", 32'(done), 1);
    chk("less_flag", 32'(cmp_flag), 0);
    step();
    chk("less_flag_hold", 32'(cmp_flag), 0);

    // Unsupported ops: err next cycle, no ALU drive, straight back to IDLE
    instr_valid = 1'b1; instr = mk(4'b0011, 3'd1, 3'd3, 3'd4);
    step();
    instr_valid = 1'b0;
    chk("div_err", 32'(err), 1);
    chk("div_ready", 32'(instr_ready), 1);
    chk("div_done", 32'(done), 0);
    chk("div_op_hold", 32'(Op), 9);
    chk("div_a1_hold", 32'(A1), 7);
    step();
    chk("div_err_clr", 32'(err), 0);
    chk("div_done2", 32'(done), 0);
    instr_valid = 1'b1; instr = mk(4'b1111, 3'd2, 3'd3, 3'd4);
    step();
    instr_valid = 1'b0;
    chk("mem_err", 32'(err), 1);
    chk("mem_ready", 32'(instr_ready), 1);
    chk("mem_op_hold", 32'(Op), 9);
    step();
    chk("mem_err_clr", 32'(err), 0);
    chk("mem_done", 32'(done), 0);
    chk_all("unsup");

    // Load and instruction together: load first, instruction one cycle later
    ld_valid = 1'b1; ld_addr = 3'd0; ld_re = 8'd9; ld_im = 8'd3;
    instr_valid = 1'b1; instr = mk(4'b0000, 3'd2, 3'd0, 3'd1);
    #1;
    chk("ldpri_ready", 32'(instr_ready), 0);
    step();
    ld_valid = 1'b0;
    er[0] = 8'd9; ei[0] = 8'd3;
    #1;
    chk("ldpri_ready2", 32'(instr_ready), 1);
    chk("ldpri_op_hold", 32'(Op), 9);
    chk_reg(0, "ldpri");
    step();
    instr_valid = 1'b0;
    chk("ldpri_a1", 32'(A1), 9);
    chk("ldpri_op", 32'(Op), 0);
    step(); step();
    chk("ldpri_done", 32'(done), 1);
    er[2] = 8'd14; ei[2] = 8'd9;
    chk_reg(2, "ldpri");
    step();

    // Reset during EXEC aborts the instruction
    instr_valid = 1'b1; instr = mk(4'b0001, 3'd3, 3'd0, 3'd1);
    step();
    instr_valid = 1'b0;
    chk("abort_op_exec", 32'(Op), 1);
    rst = 1'b1;
    step();
    chk("abort_ready", 32'(instr_ready), 0);
    chk("abort_a1", 32'(A1), 0);
    chk("abort_b1", 32'(B1), 0);
    chk("abort_op", 32'(Op), 0);
    chk("abort_flag", 32'(cmp_flag), 0);
    rst = 1'b0;
    step();
    chk("abort_done", 32'(done), 0);
    chk("abort_idle", 32'(instr_ready), 1);
    for (int i = 0; i < 8; i++) begin er[i] = '0; ei[i] = '0; end
    chk_all("abort");
    step();
    chk("abort_done2", 32'(done), 0);
    chk("abort_err", 32'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
